// File: rtl/div_32_restoring.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module div_32_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;   // partial remainder
  logic [WIDTH-1:0] shq;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next, dvd_mag, dvs_mag, quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
`endif

  always_comb begin
    shifted  = {acc, shq[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {shq[WIDTH-2:0], q_bit};
`ifdef DIV_SIGNED_EN
    dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    quo_fix  = neg_q ? -quo_next : quo_next;
    rem_fix  = neg_r ? -rem_next : rem_next;
`else
    dvd_mag  = dividend;
    dvs_mag  = divisor;
    quo_fix  = quo_next;
    rem_fix  = rem_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      shq         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
              acc         <= '0;
              shq         <= dvd_mag;
              dvs         <= dvs_mag;
              cnt         <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
              neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r       <= dividend[WIDTH-1];
`endif
            end
          end
        end
        CALC: begin
          acc <= rem_next;
          shq <= quo_next;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // last iteration: results load on the same edge that enters DONE
            quotient  <= quo_fix;
            remainder <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_restoring.sv
// Self-checking bench for div_32_restoring: directed scenarios plus randomized pairs
// checked against an arithmetic reference model (signed when DIV_SIGNED_EN is defined).
module tb_div_32_restoring;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div_32_restoring #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef DIV_SIGNED_EN
      if (b == 32'hFFFF_FFFF) begin
        q = -a; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Drives one start and returns the number of clock edges until done is seen (100 = timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(posedge clk); #1;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #10;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'd100, 32'd7, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d, required 33", lat); end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++; $display("FAIL basic_result: q=%0d r=%0d, required q=14 r=2", quotient, remainder);
    end
    checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_flags: dbz=%b busy=%b, required dbz=0 busy=1", div_by_zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_fall: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] eq, er;
    logic ez;
    run_op(32'hFFFF_FFFF, 32'd1, lat);
    ref_div(32'hFFFF_FFFF, 32'd1, eq, er, ez);
    checks++;
    if (quotient !== eq || remainder !== er || lat !== 33) begin
      errors++; $display("FAIL b2b_first: q=%h r=%h lat=%0d, required q=%h r=%h lat=33",
                         quotient, remainder, lat, eq, er);
    end
    run_op(32'h1234_5678, 32'hFFFF_FFFF, lat);
    ref_div(32'h1234_5678, 32'hFFFF_FFFF, eq, er, ez);
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== 33) begin
      errors++; $display("FAIL b2b_second: q=%h r=%h dbz=%b lat=%0d, required q=%h r=%h dbz=%b lat=33",
                         quotient, remainder, div_by_zero, lat, eq, er, ez);
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    run_op(32'hDEAD_BEEF, 32'd0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d, required 1", lat); end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hDEAD_BEEF || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_result: q=%h r=%h dbz=%b, required q=ffffffff r=deadbeef dbz=1",
                         quotient, remainder, div_by_zero);
    end
    run_op(32'd9, 32'd3, lat);
    checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0 || lat !== 33) begin
      errors++; $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b lat=%0d, required q=3 r=0 dbz=0 lat=33",
                         quotient, remainder, div_by_zero, lat);
    end
  endtask

  task automatic test_ignore_start();
    int npulse = 0;
    int first = 0;
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = (c == 10);
      if (c == 10) begin dividend = 32'd55; divisor = 32'd5; end
      if (done === 1'b1) begin
        npulse++;
        if (first == 0) first = c;
      end
    end
    checks++;
    if (npulse !== 1 || first !== 33) begin
      errors++; $display("FAIL ignore_done: pulses=%0d first=%0d, required 1 pulse at 33", npulse, first);
    end
    checks++;
    if (quotient !== 32'd111 || remainder !== 32'd1) begin
      errors++; $display("FAIL ignore_result: q=%0d r=%0d, required q=111 r=1", quotient, remainder);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int npulse = 0;
    logic [31:0] eq, er;
    logic ez;
    run_op(32'd5, 32'd0, lat);
    @(posedge clk); #1;
    dividend = 32'd77777; divisor = 32'd13; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      errors++; $display("FAIL midreset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
                         busy, done, div_by_zero, quotient, remainder);
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) npulse++;
    end
    checks++;
    if (npulse !== 0) begin errors++; $display("FAIL midreset_no_done: pulses=%0d, required 0", npulse); end
    run_op(32'd1234567, 32'd89, lat);
    ref_div(32'd1234567, 32'd89, eq, er, ez);
    checks++;
    if (quotient !== eq || remainder !== er || lat !== 33) begin
      errors++; $display("FAIL midreset_recover: q=%0d r=%0d lat=%0d, required q=%0d r=%0d lat=33",
                         quotient, remainder, lat, eq, er);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat;
    run_op(-32'sd7, 32'd2, lat);
    checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL signed_neg7_div2: q=%h r=%h, required fffffffd ffffffff", quotient, remainder);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
      errors++; $display("FAIL signed_overflow: q=%h r=%h, required 80000000 00000000", quotient, remainder);
    end
  endtask
`endif

  task automatic test_random();
    int lat, elat;
    logic [31:0] a, b, eq, er;
    logic ez;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 1000);
        4:       b = a + $urandom_range(1, 5);
        5:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'd0;
      run_op(a, b, lat);
      ref_div(a, b, eq, er, ez);
      elat = ez ? 1 : 33;
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== elat) begin
        errors++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dbz=%b lat=%0d, required q=%h r=%h dbz=%b lat=%0d",
                 i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_ignore_start();
    test_mid_reset();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
